// File: rtl/td4_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : td4_ctrl_pkg
// Description : Shared opcode encodings and sequencer state type for the
//               TD4 control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package td4_ctrl_pkg;

    localparam logic [3:0] OP_ADD_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_RR = 4'b0001;
    localparam logic [3:0] OP_IN     = 4'b0010;
    localparam logic [3:0] OP_MOV_IM = 4'b0011;
    localparam logic [3:0] OP_OUT_R  = 4'b1001;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage : td4_ctrl_pkg
`default_nettype wire

// File: rtl/td4_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : td4_op_decode
// Description : Combinational TD4 instruction decoder. Produces the next
//               register/output/PC load strobes, the source select and an
//               illegal flag (undefined opcode or out-of-range index).
//               Strobes are forced to 0 for illegal instructions; the select
//               is left to the caller to sanitise.
// Revision    : 1.0 - initial release
// ============================================================================
module td4_op_decode
    import td4_ctrl_pkg::*;
#(
    parameter  int NREG = 2,
    localparam int RW   = $clog2(NREG),
    localparam int SW   = $clog2(NREG + 2)
) (
    input  logic [3:0]      op_i,
    input  logic [RW-1:0]   rd_i,
    input  logic [RW-1:0]   rs_i,
    input  logic            carry_i,
    output logic [NREG-1:0] ld_reg_o,
    output logic            ld_out_o,
    output logic            ld_pc_o,
    output logic [SW-1:0]   sel_o,
    output logic            illegal_o
);

    localparam logic [SW-1:0] c_SEL_IN  = SW'(NREG);
    localparam logic [SW-1:0] c_SEL_IMM = SW'(NREG + 1);

    logic [NREG-1:0] w_rd_onehot;
    logic            w_idx_bad;

    // One-hot expansion of the destination index
    always_comb begin
        w_rd_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            w_rd_onehot[i] = (rd_i == RW'(i));
        end
    end

    // Opcode decode; any index outside the register file is illegal
    always_comb begin
        ld_reg_o  = '0;
        ld_out_o  = 1'b0;
        ld_pc_o   = 1'b0;
        sel_o     = '0;
        illegal_o = 1'b0;
        w_idx_bad = (int'(rd_i) >= NREG) || (int'(rs_i) >= NREG);

        case (op_i)
            OP_ADD_IM, OP_MOV_IM: begin
                ld_reg_o = w_rd_onehot;
                sel_o    = c_SEL_IMM;
            end
            OP_MOV_RR: begin
                ld_reg_o = w_rd_onehot;
                sel_o    = SW'(rs_i);
            end
            OP_IN: begin
                ld_reg_o = w_rd_onehot;
                sel_o    = c_SEL_IN;
            end
            OP_OUT_R: begin
                ld_out_o = 1'b1;
                sel_o    = SW'(rs_i);
            end
            OP_OUT_IM: begin
                ld_out_o = 1'b1;
                sel_o    = c_SEL_IMM;
            end
            OP_JNC: begin
                ld_pc_o  = ~carry_i;
                sel_o    = c_SEL_IMM;
            end
            OP_JMP: begin
                ld_pc_o  = 1'b1;
                sel_o    = c_SEL_IMM;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase

        if (w_idx_bad) begin
            illegal_o = 1'b1;
        end

        if (illegal_o) begin
            ld_reg_o = '0;
            ld_out_o = 1'b0;
            ld_pc_o  = 1'b0;
        end
    end

endmodule : td4_op_decode
`default_nettype wire

// File: rtl/td4_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : td4_ctrl_seq
// Description : Registered TD4 control sequencer for NREG registers.
//               FETCH accepts one instruction per handshake, EXEC presents
//               its strobes for one cycle and captures the ALU carry.
//               Build option TD4_CTRL_TRAP_EN: undefined instructions halt
//               the sequencer with a sticky trap; otherwise they run as NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module td4_ctrl_seq
    import td4_ctrl_pkg::*;
#(
    parameter  int NREG = 2,
    localparam int RW   = $clog2(NREG),
    localparam int SW   = $clog2(NREG + 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_op,
    input  logic [RW-1:0]   instr_rd,
    input  logic [RW-1:0]   instr_rs,
    input  logic            carry_in,
    output logic [NREG-1:0] ld_reg,
    output logic            ld_out,
    output logic            ld_pc,
    output logic [SW-1:0]   sel,
    output logic            carry_q,
    output logic            trap
);

    logic [NREG-1:0] w_ld_reg;
    logic            w_ld_out;
    logic            w_ld_pc;
    logic [SW-1:0]   w_sel;
    logic            w_illegal;

    state_e          state_q;
    logic [NREG-1:0] ld_reg_q;
    logic            ld_out_q;
    logic            ld_pc_q;
    logic [SW-1:0]   sel_q;
    logic            flag_q;

    td4_op_decode #(
        .NREG (NREG)
    ) u_decode (
        .op_i      (instr_op),
        .rd_i      (instr_rd),
        .rs_i      (instr_rs),
        .carry_i   (flag_q),
        .ld_reg_o  (w_ld_reg),
        .ld_out_o  (w_ld_out),
        .ld_pc_o   (w_ld_pc),
        .sel_o     (w_sel),
        .illegal_o (w_illegal)
    );

`ifdef TD4_CTRL_TRAP_EN
    logic trap_q;
`endif

    // Sequencer FSM with registered strobes, select, carry flag and trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            ld_reg_q <= '0;
            ld_out_q <= 1'b0;
            ld_pc_q  <= 1'b0;
            sel_q    <= '0;
            flag_q   <= 1'b0;
`ifdef TD4_CTRL_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle pulses unless a handshake reloads them
            ld_reg_q <= '0;
            ld_out_q <= 1'b0;
            ld_pc_q  <= 1'b0;

            case (state_q)
                ST_FETCH: begin
                    if (instr_valid) begin
`ifdef TD4_CTRL_TRAP_EN
                        if (w_illegal) begin
                            sel_q   <= '0;
                            trap_q  <= 1'b1;
                            state_q <= ST_HALT;
                        end else begin
                            ld_reg_q <= w_ld_reg;
                            ld_out_q <= w_ld_out;
                            ld_pc_q  <= w_ld_pc;
                            sel_q    <= w_sel;
                            state_q  <= ST_EXEC;
                        end
`else
                        // Illegal words run as NOP: decoder already
                        // suppressed their strobes
                        ld_reg_q <= w_ld_reg;
                        ld_out_q <= w_ld_out;
                        ld_pc_q  <= w_ld_pc;
                        sel_q    <= w_illegal ? '0 : w_sel;
                        state_q  <= ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    flag_q  <= carry_in;
                    state_q <= ST_FETCH;
                end
`ifdef TD4_CTRL_TRAP_EN
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
`endif
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign instr_ready = (state_q == ST_FETCH);
    assign ld_reg      = ld_reg_q;
    assign ld_out      = ld_out_q;
    assign ld_pc       = ld_pc_q;
    assign sel         = sel_q;
    assign carry_q     = flag_q;

`ifdef TD4_CTRL_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule : td4_ctrl_seq
`default_nettype wire
